// File: rtl/cla_pkg.sv
// Shared constants, types and group generate/propagate helper for the pipelined CLA adder.
package cla_pkg;

  localparam int unsigned CLA_GROUP = 4;

  typedef struct packed {
    logic g;
    logic p;
  } grp_gp_t;

  // Collapse 4-bit generate/propagate vectors into one group generate/propagate pair.
  function automatic grp_gp_t grp_gp(input logic [3:0] g, input logic [3:0] p);
    grp_gp_t r;
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.p = &p;
    return r;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead slice: sum, group generate/propagate and the carry into each bit.
module cla_group4
  import cla_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] sum_o,
  output logic       g_o,
  output logic       p_o,
  output logic [3:0] c_o
);

  logic [3:0] g;
  logic [3:0] p;
  grp_gp_t    gp;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // c_o[i] is the carry into bit i, all flattened to two-level logic.
  assign c_o[0] = c_i;
  assign c_o[1] = g[0] | (p[0] & c_i);
  assign c_o[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c_o[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);

  assign sum_o = p ^ c_o;

  assign gp  = grp_gp(g, p);
  assign g_o = gp.g;
  assign p_o = gp.p;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined CLA adder/subtractor with valid/ready flow control.
// Define CLA_SATURATE_EN to clamp the sum to the signed range on overflow.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NG = WIDTH / CLA_GROUP;

  // Flow control
  logic adv1;
  logic adv2;
  logic v1_q;
  logic v2_q;

  assign adv2     = ~v2_q | out_ready;
  assign adv1     = ~v1_q | adv2;
  assign in_ready = adv1;

  // Stage 1: operand conditioning and group generate/propagate
  logic [WIDTH-1:0] b_mod;
  logic             c0_d;
  logic [NG-1:0]    g1_d;
  logic [NG-1:0]    p1_d;
  grp_gp_t          gp;

  always_comb begin
    b_mod = op_sub ? ~b : b;
    c0_d  = op_sub ? 1'b1 : cin;
    g1_d  = '0;
    p1_d  = '0;
    gp    = '0;
    for (int k = 0; k < NG; k++) begin
      gp = grp_gp(a[k*CLA_GROUP +: CLA_GROUP] & b_mod[k*CLA_GROUP +: CLA_GROUP],
                  a[k*CLA_GROUP +: CLA_GROUP] ^ b_mod[k*CLA_GROUP +: CLA_GROUP]);
      g1_d[k] = gp.g;
      p1_d[k] = gp.p;
    end
  end

  logic [WIDTH-1:0] a1_q;
  logic [WIDTH-1:0] b1_q;
  logic             c0_q;
  logic [NG-1:0]    g1_q;
  logic [NG-1:0]    p1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      c0_q <= 1'b0;
      g1_q <= '0;
      p1_q <= '0;
    end else if (adv1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        a1_q <= a;
        b1_q <= b_mod;
        c0_q <= c0_d;
        g1_q <= g1_d;
        p1_q <= p1_d;
      end
    end
  end

  // Stage 2: group-level lookahead, then per-group sums
  logic [NG:0] grp_c;

  always_comb begin
    grp_c    = '0;
    grp_c[0] = c0_q;
    for (int k = 0; k < NG; k++) begin
      grp_c[k+1] = g1_q[k] | (p1_q[k] & grp_c[k]);
    end
  end

  logic [WIDTH-1:0] sum_raw;
  logic [WIDTH-1:0] bit_c;
  logic [NG-1:0]    inst_g;
  logic [NG-1:0]    inst_p;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .a_i  (a1_q[k*CLA_GROUP +: CLA_GROUP]),
      .b_i  (b1_q[k*CLA_GROUP +: CLA_GROUP]),
      .c_i  (grp_c[k]),
      .sum_o(sum_raw[k*CLA_GROUP +: CLA_GROUP]),
      .g_o  (inst_g[k]),
      .p_o  (inst_p[k]),
      .c_o  (bit_c[k*CLA_GROUP +: CLA_GROUP])
    );
  end

  // Slice G/P duplicate the registered stage-1 values; only the MSB carry-in is needed here.
  logic unused_grp;
  assign unused_grp = ^{inst_g, inst_p, bit_c[WIDTH-2:0]};

  logic             cout_d;
  logic             ovf_d;
  logic [WIDTH-1:0] sum_d;

  assign cout_d = grp_c[NG];
  assign ovf_d  = bit_c[WIDTH-1] ^ grp_c[NG];

`ifdef CLA_SATURATE_EN
  logic [WIDTH-1:0] sat_val;
  always_comb begin
    sat_val          = '0;
    sat_val[WIDTH-1] = a1_q[WIDTH-1];
    for (int i = 0; i < WIDTH - 1; i++) begin
      sat_val[i] = ~a1_q[WIDTH-1];
    end
    sum_d = ovf_d ? sat_val : sum_raw;
  end
`else
  assign sum_d = sum_raw;
`endif

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = v2_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder at WIDTH=16.
module tb_cla_pipe_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int total;
  int bad;

`ifdef CLA_SATURATE_EN
  localparam logic [15:0] ExpOvfAdd = 16'h7FFF;
  localparam logic [15:0] ExpOvfSub = 16'h8000;
`else
  localparam logic [15:0] ExpOvfAdd = 16'h8000;
  localparam logic [15:0] ExpOvfSub = 16'h7FFF;
`endif

  cla_pipe_adder #(
    .WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .op_sub   (op_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, confirm the block is ready, and let it be accepted on the next edge.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                       input logic sub);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = ci;
    op_sub   = sub;
    #1;
    chk("issue_ready", {31'd0, in_ready}, 32'd1);
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    op_sub   = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] s, input logic c, input logic o);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, s});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, c});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, o});
  endtask

  task automatic single(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sub, input logic [15:0] s, input logic c,
                        input logic o);
    issue(av, bv, ci, sub);
    idle();
    chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk_out(tag, s, c, o);
    tick();
    chk({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic pair(input string tag,
                      input logic [15:0] a0, input logic [15:0] b0, input logic ci0,
                      input logic sub0, input logic [15:0] s0, input logic c0, input logic o0,
                      input logic [15:0] a1, input logic [15:0] b1, input logic ci1,
                      input logic sub1, input logic [15:0] s1, input logic c1, input logic o1);
    issue(a0, b0, ci0, sub0);
    chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    issue(a1, b1, ci1, sub1);
    idle();
    chk_out({tag, "_0"}, s0, c0, o0);
    tick();
    chk_out({tag, "_1"}, s1, c1, o1);
    tick();
    chk({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    out_ready = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    single("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    pair("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0,
                      16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    pair("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, ExpOvfAdd, 1'b0, 1'b1,
                16'h8000, 16'h0001, 1'b0, 1'b1, ExpOvfSub, 1'b1, 1'b1);
    pair("sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0,
                16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    single("add_all_groups", 16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Backpressure: two beats fill the pipe, the third waits until the output drains.
    out_ready = 1'b0;
    issue(16'h0010, 16'h0001, 1'b0, 1'b0);
    issue(16'h0100, 16'h0001, 1'b0, 1'b1);
    a        = 16'hAAAA;
    b        = 16'h5555;
    cin      = 1'b1;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    chk_out("bp_hold0", 16'h0011, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
      chk_out("bp_hold", 16'h0011, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    idle();
    chk_out("bp_out1", 16'h00FF, 1'b1, 1'b0);
    tick();
    chk_out("bp_out2", 16'h0000, 1'b1, 1'b0);
    tick();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    // Reset with two beats in flight discards them.
    issue(16'h1111, 16'h1111, 1'b0, 1'b0);
    issue(16'h2222, 16'h2222, 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum", {16'd0, sum}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    single("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
